// File: rtl/video_pkg.sv
// Shared video definitions: character geometry and the sync/active control bundle
// passed between the generator, this shifter and the scan output.
package video_pkg;

  localparam int CHAR_WIDTH  = 8;
  localparam int REVERSE_BIT = 7;

  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic active;
  } vid_ctl_t;

endpackage

// File: rtl/video_delay_line.sv
// Enable-advanced shift line of DEPTH words; DEPTH=0 is a plain wire so the
// caller's own output register is the only stage.
module video_delay_line #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  if (DEPTH == 0) begin : gPass
    logic unusedPass;
    assign unusedPass = clock_i ^ reset_i ^ enable_i;
    assign data_o     = data_i;
  end else begin : gShift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (enable_i) begin
        stage_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign data_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_shifter.sv
// Character-cell output stage: latches the RAM/ROM bytes fetched by video_gen,
// serialises the glyph MSB-first with reverse video, and aligns the syncs.
module video_shifter
  import video_pkg::*;
#(
  parameter bit INVERT_VIDEO = 1'b0,
  parameter int SYNC_DELAY   = 8
) (
  input  logic                  clk16,
  input  logic                  reset,
  input  logic                  pixel_en,
  input  logic                  char_load,
  input  logic [CHAR_WIDTH-1:0] data_in,
  input  logic                  video_ram_strobe,
  input  logic                  video_rom_strobe,
  input  logic                  h_active,
  input  logic                  v_active,
  input  logic                  h_sync,
  input  logic                  v_sync,
  output logic                  video,
  output logic                  h_sync_out,
  output logic                  v_sync_out,
  output logic                  active_out
);

  logic                  ramStrobe_q, romStrobe_q;
  logic [CHAR_WIDTH-1:0] ramLatch_q, ramLatch_d;
  logic [CHAR_WIDTH-1:0] romLatch_q, romLatch_d;
  logic [CHAR_WIDTH-1:0] shift_q, shift_d;
  logic                  rev_q, rev_d;
  logic                  video_q, video_d;
  logic                  load, ramFall, romFall, pixel;
  vid_ctl_t              ctlIn, ctlTail, ctlOut_q;

  assign load    = char_load & pixel_en;
  assign ramFall = ramStrobe_q & ~video_ram_strobe;
  assign romFall = romStrobe_q & ~video_rom_strobe;
  assign ctlIn   = {h_sync, v_sync, h_active & v_active};

  video_delay_line #(
    .DEPTH(SYNC_DELAY),
    .WIDTH($bits(vid_ctl_t))
  ) uDelay (
    .clock_i (clk16),
    .reset_i (reset),
    .enable_i(pixel_en),
    .data_i  (ctlIn),
    .data_o  (ctlTail)
  );

  // The pixel is taken from the next shifter state, so the register output
  // tracks the shifter and naturally holds between pixel_en pulses.
  always_comb begin
    ramLatch_d = ramLatch_q;
    romLatch_d = romLatch_q;
    shift_d    = shift_q;
    rev_d      = rev_q;
    if (load) begin
      shift_d    = romLatch_q;
      rev_d      = ramLatch_q[REVERSE_BIT];
      ramLatch_d = '0;
      romLatch_d = '0;
    end else if (pixel_en) begin
      shift_d = {shift_q[CHAR_WIDTH-2:0], 1'b0};
    end
    if (ramFall) ramLatch_d = data_in;
    if (romFall) romLatch_d = data_in;
    pixel   = shift_d[CHAR_WIDTH-1] ^ rev_d ^ INVERT_VIDEO;
    video_d = pixel & ctlTail.active;
  end

  always_ff @(posedge clk16) begin
    if (reset) begin
      ramStrobe_q <= 1'b0;
      romStrobe_q <= 1'b0;
      ramLatch_q  <= '0;
      romLatch_q  <= '0;
      shift_q     <= '0;
      rev_q       <= 1'b0;
      video_q     <= 1'b0;
      ctlOut_q    <= '0;
    end else begin
      ramStrobe_q <= video_ram_strobe;
      romStrobe_q <= video_rom_strobe;
      ramLatch_q  <= ramLatch_d;
      romLatch_q  <= romLatch_d;
      shift_q     <= shift_d;
      rev_q       <= rev_d;
      video_q     <= video_d;
      ctlOut_q    <= ctlTail;
    end
  end

  assign video      = video_q;
  assign h_sync_out = ctlOut_q.h_sync;
  assign v_sync_out = ctlOut_q.v_sync;
  assign active_out = ctlOut_q.active;

endmodule

// File: tb/tb_video_shifter.sv
// Bench for video_shifter: two instances (normal/8-deep, inverted/pass-through)
// checked every cycle against a cell-level model, plus vector tables and corner sequences.
module tb_video_shifter;

  localparam int NDUT = 2;
  localparam int DLY0 = 8;
  localparam int DLY1 = 0;

  logic clk16 = 1'b0;
  always #5 clk16 = ~clk16;

  logic            reset, pixel_en, char_load, ramStb, romStb;
  logic            hAct, vAct, hSync, vSync;
  logic [7:0]      dataIn;
  logic [NDUT-1:0] video, hsOut, vsOut, actOut;

  video_shifter #(.INVERT_VIDEO(1'b0), .SYNC_DELAY(DLY0)) dut (
    .clk16(clk16), .reset(reset), .pixel_en(pixel_en), .char_load(char_load),
    .data_in(dataIn), .video_ram_strobe(ramStb), .video_rom_strobe(romStb),
    .h_active(hAct), .v_active(vAct), .h_sync(hSync), .v_sync(vSync),
    .video(video[0]), .h_sync_out(hsOut[0]), .v_sync_out(vsOut[0]), .active_out(actOut[0])
  );

  video_shifter #(.INVERT_VIDEO(1'b1), .SYNC_DELAY(DLY1)) dutInv (
    .clk16(clk16), .reset(reset), .pixel_en(pixel_en), .char_load(char_load),
    .data_in(dataIn), .video_ram_strobe(ramStb), .video_rom_strobe(romStb),
    .h_active(hAct), .v_active(vAct), .h_sync(hSync), .v_sync(vSync),
    .video(video[1]), .h_sync_out(hsOut[1]), .v_sync_out(vsOut[1]), .active_out(actOut[1])
  );

  int errors = 0;
  int checks = 0;
  int cycleCount = 0;

  // Model state: latches, the glyph being drawn with a pixel index, and a
  // history of control samples taken on each pixel tick.
  logic       mRamPrev = 1'b0, mRomPrev = 1'b0;
  logic [7:0] mRamLat = '0, mRomLat = '0, mCellBits = '0;
  logic       mCellRev = 1'b0;
  int         mPixIdx = 8;
  logic [2:0] mHist[$];
  logic [NDUT-1:0] expVideo, expHs, expVs, expAct;

  function automatic int dlyOf(int m);
    return (m == 0) ? DLY0 : DLY1;
  endfunction

  function automatic logic invOf(int m);
    return (m == 1);
  endfunction

  task automatic modelStep();
    logic load, ramFall, romFall, pix, glyphBit;
    logic [2:0] ctlNow, tail;
    if (reset) begin
      mRamPrev = 1'b0; mRomPrev = 1'b0;
      mRamLat = '0; mRomLat = '0; mCellBits = '0; mCellRev = 1'b0; mPixIdx = 8;
      mHist.delete();
      for (int i = 0; i < 8; i++) mHist.push_back(3'b000);
      expVideo = '0; expHs = '0; expVs = '0; expAct = '0;
      return;
    end
    load    = char_load & pixel_en;
    ramFall = mRamPrev & ~ramStb;
    romFall = mRomPrev & ~romStb;
    if (load) begin
      mCellBits = mRomLat;
      mCellRev  = mRamLat[7];
      mPixIdx   = 0;
      mRamLat   = '0;
      mRomLat   = '0;
    end else if (pixel_en && mPixIdx < 8) begin
      mPixIdx++;
    end
    if (ramFall) mRamLat = dataIn;
    if (romFall) mRomLat = dataIn;
    mRamPrev = ramStb;
    mRomPrev = romStb;
    ctlNow = {hSync, vSync, hAct & vAct};
    glyphBit = (mPixIdx < 8) ? mCellBits[3'(7 - mPixIdx)] : 1'b0;
    for (int m = 0; m < NDUT; m++) begin
      tail = (dlyOf(m) == 0) ? ctlNow : mHist[mHist.size() - dlyOf(m)];
      pix  = glyphBit ^ mCellRev ^ invOf(m);
      expVideo[m] = pix & tail[0];
      expHs[m]    = tail[2];
      expVs[m]    = tail[1];
      expAct[m]   = tail[0];
    end
    if (pixel_en) begin
      mHist.push_back(ctlNow);
      void'(mHist.pop_front());
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %b, wanted %b", name, cycleCount, got, want);
    end
  endtask

  task automatic checkByte(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, wanted %h", name, cycleCount, got, want);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, wanted %0d", name, cycleCount, got, want);
    end
  endtask

  task automatic checkOutput();
    for (int m = 0; m < NDUT; m++) begin
      checkBit($sformatf("video[%0d]", m), video[m], expVideo[m]);
      checkBit($sformatf("h_sync_out[%0d]", m), hsOut[m], expHs[m]);
      checkBit($sformatf("v_sync_out[%0d]", m), vsOut[m], expVs[m]);
      checkBit($sformatf("active_out[%0d]", m), actOut[m], expAct[m]);
    end
  endtask

  // One clk16 cycle with the current inputs; pixel_en alternates every cycle.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk16);
    #1;
    cycleCount++;
    checkOutput();
    pixel_en = ~pixel_en;
  endtask

  task automatic idle(input int ticks);
    char_load = 1'b0; ramStb = 1'b0; romStb = 1'b0;
    repeat (2 * ticks) applyStimulus();
  endtask

  task automatic fetch(input logic [7:0] ram, input logic [7:0] rom);
    char_load = 1'b0;
    ramStb = 1'b1; dataIn = ram; applyStimulus();
    ramStb = 1'b0;               applyStimulus();
    romStb = 1'b1; dataIn = rom; applyStimulus();
    romStb = 1'b0;               applyStimulus();
    dataIn = 8'h00;
  endtask

  task automatic loadAndCollect(output logic [7:0] got0, output logic [7:0] got1);
    if (!pixel_en) applyStimulus();
    char_load = 1'b1;
    applyStimulus();
    char_load = 1'b0;
    got0[7] = video[0];
    got1[7] = video[1];
    for (int k = 6; k >= 0; k--) begin
      applyStimulus();
      applyStimulus();
      got0[k] = video[0];
      got1[k] = video[1];
    end
  endtask

  typedef struct {
    logic [7:0] ram;
    logic [7:0] rom;
    logic       hA;
    logic       vA;
    logic [7:0] exp0;
    logic [7:0] exp1;
    logic       ninth0;
    logic       ninth1;
    logic       act;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] got0, got1;
    int rise0, rise1, high0, high1, vrise0, vrise1;

    vecs[0] = '{ram:8'h01, rom:8'hA5, hA:1'b1, vA:1'b1, exp0:8'hA5, exp1:8'h5A, ninth0:1'b0, ninth1:1'b1, act:1'b1};
    vecs[1] = '{ram:8'h81, rom:8'hA5, hA:1'b1, vA:1'b1, exp0:8'h5A, exp1:8'hA5, ninth0:1'b1, ninth1:1'b0, act:1'b1};
    vecs[2] = '{ram:8'h00, rom:8'hFF, hA:1'b1, vA:1'b0, exp0:8'h00, exp1:8'h00, ninth0:1'b0, ninth1:1'b0, act:1'b0};
    vecs[3] = '{ram:8'h80, rom:8'h00, hA:1'b1, vA:1'b1, exp0:8'hFF, exp1:8'h00, ninth0:1'b1, ninth1:1'b0, act:1'b1};

    reset = 1'b1; pixel_en = 1'b0; char_load = 1'b0; ramStb = 1'b0; romStb = 1'b0;
    hAct = 1'b0; vAct = 1'b0; hSync = 1'b0; vSync = 1'b0; dataIn = 8'h00;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      hAct = vecs[i].hA;
      vAct = vecs[i].vA;
      idle(10);
      fetch(vecs[i].ram, vecs[i].rom);
      loadAndCollect(got0, got1);
      checkByte($sformatf("vec%0d cell", i), got0, vecs[i].exp0);
      checkByte($sformatf("vec%0d cellInv", i), got1, vecs[i].exp1);
      checkBit($sformatf("vec%0d active_out", i), actOut[0], vecs[i].act);
      applyStimulus();
      applyStimulus();
      checkBit($sformatf("vec%0d ninth", i), video[0], vecs[i].ninth0);
      checkBit($sformatf("vec%0d ninthInv", i), video[1], vecs[i].ninth1);
    end

    $display("[TB] capture racing char_load");
    hAct = 1'b1; vAct = 1'b1;
    idle(10);
    fetch(8'h00, 8'h0F);
    if (pixel_en) applyStimulus();
    romStb = 1'b1; dataIn = 8'hFF;
    applyStimulus();
    romStb = 1'b0;
    loadAndCollect(got0, got1);
    dataIn = 8'h00;
    checkByte("raceCurrent", got0, 8'h0F);
    checkByte("raceCurrentInv", got1, 8'hF0);
    loadAndCollect(got0, got1);
    checkByte("raceNext", got0, 8'hFF);
    checkByte("raceNextInv", got1, 8'h00);

    $display("[TB] reset mid-cell");
    idle(10);
    fetch(8'h80, 8'hFF);
    if (!pixel_en) applyStimulus();
    char_load = 1'b1;
    applyStimulus();
    char_load = 1'b0;
    repeat (5) applyStimulus();
    fetch(8'h80, 8'hFF);
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    for (int m = 0; m < NDUT; m++) begin
      checkBit($sformatf("resetVideo%0d", m), video[m], 1'b0);
      checkBit($sformatf("resetHs%0d", m), hsOut[m], 1'b0);
      checkBit($sformatf("resetVs%0d", m), vsOut[m], 1'b0);
      checkBit($sformatf("resetAct%0d", m), actOut[m], 1'b0);
    end
    idle(10);
    loadAndCollect(got0, got1);
    checkByte("postResetCell", got0, 8'h00);
    checkByte("postResetCellInv", got1, 8'hFF);

    $display("[TB] sync alignment");
    idle(10);
    if (pixel_en) applyStimulus();
    hSync = 1'b1; vSync = 1'b1;
    rise0 = -1; rise1 = -1; vrise0 = -1; vrise1 = -1; high0 = 0; high1 = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        hSync = 1'b0; vSync = 1'b0;
      end
      applyStimulus();
      if (hsOut[0] && rise0 < 0) rise0 = c;
      if (hsOut[1] && rise1 < 0) rise1 = c;
      if (vsOut[0] && vrise0 < 0) vrise0 = c;
      if (vsOut[1] && vrise1 < 0) vrise1 = c;
      if (hsOut[0]) high0++;
      if (hsOut[1]) high1++;
    end
    checkInt("hsRiseCycle", rise0, 17);
    checkInt("hsWidth", high0, 4);
    checkInt("vsRiseCycle", vrise0, 17);
    checkInt("hsRiseCyclePass", rise1, 1);
    checkInt("hsWidthPass", high1, 4);
    checkInt("vsRiseCyclePass", vrise1, 1);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 800; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      char_load = ($urandom_range(0, 7) == 0);
      ramStb    = 1'($urandom_range(0, 1));
      romStb    = 1'($urandom_range(0, 1));
      dataIn    = 8'($urandom);
      hAct      = ($urandom_range(0, 3) != 0);
      vAct      = ($urandom_range(0, 3) != 0);
      hSync     = ($urandom_range(0, 5) == 0);
      vSync     = ($urandom_range(0, 5) == 0);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: bench still running at cycle %0d", cycleCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
